// File: rtl/ctrl_port_sim.sv
// Virtual serial game-controller ports: each port has a parallel-load
// shift register with fill, saturating read counter, latch-edge pulse and
// a shared turbo phase that gates masked buttons.
module ctrl_port_sim #(
  parameter int   PORTS        = 2,
  parameter int   BITS         = 8,
  parameter logic FILL         = 1'b1,
  parameter int   TURBO_PERIOD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORTS-1:0]      strobe,
  input  logic [PORTS-1:0]      rd,
  input  logic [PORTS*BITS-1:0] btns,
  input  logic [PORTS*BITS-1:0] turbo_mask,
  output logic [PORTS-1:0]      data,
  output logic [PORTS-1:0]      latch_pulse,
  output logic [PORTS-1:0]      reads_done
);

  localparam int CNT_W = $clog2(BITS + 1);
  localparam int TC_W  = $clog2(TURBO_PERIOD) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BITS);
  localparam logic [TC_W-1:0]  TC_LAST = TC_W'(TURBO_PERIOD - 1);

  logic [PORTS-1:0][BITS-1:0]  shreg_q, shreg_d;
  logic [PORTS-1:0][CNT_W-1:0] count_q, count_d;
  logic [PORTS-1:0]            strobe_q, strobe_d;
  logic [PORTS-1:0]            rd_q, rd_d;
  logic [PORTS-1:0]            data_q, data_d;
  logic [PORTS-1:0]            latch_pulse_q, latch_pulse_d;
  logic [PORTS-1:0]            reads_done_q, reads_done_d;
  logic                        turbo_phase_q, turbo_phase_d;
  logic [TC_W-1:0]             turbo_cnt_q, turbo_cnt_d;

  logic [PORTS-1:0][BITS-1:0]  eff;
  logic [PORTS-1:0][BITS:0]    shifted;

  // Button values after turbo gating, and the fill-in shifted register image.
  always_comb begin
    eff     = '0;
    shifted = '0;
    for (int p = 0; p < PORTS; p++) begin
      eff[p]     = btns[p*BITS +: BITS] &
                   ~(turbo_mask[p*BITS +: BITS] & {BITS{~turbo_phase_q}});
      shifted[p] = {FILL, shreg_q[p]} >> 1;
    end
  end

  // Next-state: load beats shift; data and reads_done mirror the next
  // register contents so data tracks btns one cycle after a load edge.
  always_comb begin
    shreg_d       = shreg_q;
    count_d       = count_q;
    strobe_d      = strobe;
    rd_d          = rd;
    data_d        = data_q;
    latch_pulse_d = '0;
    reads_done_d  = reads_done_q;
    turbo_phase_d = turbo_phase_q;
    turbo_cnt_d   = turbo_cnt_q;

    for (int p = 0; p < PORTS; p++) begin
      if (strobe[p]) begin
        shreg_d[p] = eff[p];
        count_d[p] = '0;
      end else if (rd_q[p] && !rd[p]) begin
        shreg_d[p] = shifted[p][BITS-1:0];
        if (count_q[p] != CNT_MAX) begin
          count_d[p] = count_q[p] + CNT_W'(1);
        end
      end
      data_d[p]        = shreg_d[p][0];
      reads_done_d[p]  = (count_d[p] == CNT_MAX);
      latch_pulse_d[p] = strobe_q[p] & ~strobe[p];
    end

    // Turbo is paced by port-0 latches only; >= recovers from any odd count.
    if (strobe_q[0] && !strobe[0]) begin
      if (turbo_cnt_q >= TC_LAST) begin
        turbo_cnt_d   = '0;
        turbo_phase_d = ~turbo_phase_q;
      end else begin
        turbo_cnt_d = turbo_cnt_q + TC_W'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q       <= '0;
      count_q       <= '0;
      strobe_q      <= '0;
      rd_q          <= '0;
      data_q        <= '0;
      latch_pulse_q <= '0;
      reads_done_q  <= '0;
      turbo_phase_q <= 1'b1;
      turbo_cnt_q   <= '0;
    end else begin
      shreg_q       <= shreg_d;
      count_q       <= count_d;
      strobe_q      <= strobe_d;
      rd_q          <= rd_d;
      data_q        <= data_d;
      latch_pulse_q <= latch_pulse_d;
      reads_done_q  <= reads_done_d;
      turbo_phase_q <= turbo_phase_d;
      turbo_cnt_q   <= turbo_cnt_d;
    end
  end

  assign data        = data_q;
  assign latch_pulse = latch_pulse_q;
  assign reads_done  = reads_done_q;

endmodule

// File: tb/tb_ctrl_port_sim.sv
// Bench for ctrl_port_sim: a 2-port 8-bit instance with turbo period 2 and
// a 1-port 16-bit extended-pad instance.
module tb_ctrl_port_sim;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [1:0]  strobe_a = '0, rd_a = '0;
  logic [15:0] btns_a = '0, tmask_a = '0;
  logic [1:0]  data_a, lp_a, done_a;

  logic [0:0]  strobe_b = '0, rd_b = '0;
  logic [15:0] btns_b = '0, tmask_b = '0;
  logic [0:0]  data_b, lp_b, done_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] data;
    logic [1:0] done;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [9:0] exp0;
    logic [9:0] exp1;
  } vec_t;
  vec_t vecs[4];

  ctrl_port_sim #(.PORTS(2), .BITS(8), .FILL(1'b1), .TURBO_PERIOD(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .strobe(strobe_a), .rd(rd_a),
    .btns(btns_a), .turbo_mask(tmask_a),
    .data(data_a), .latch_pulse(lp_a), .reads_done(done_a)
  );

  ctrl_port_sim #(.PORTS(1), .BITS(16), .FILL(1'b1), .TURBO_PERIOD(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .strobe(strobe_b), .rd(rd_b),
    .btns(btns_b), .turbo_mask(tmask_b),
    .data(data_b), .latch_pulse(lp_b), .reads_done(done_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic latch_a(input logic [1:0] m);
    strobe_a = m; cyc();
    strobe_a = '0; cyc();
  endtask

  task automatic read_a(input logic [1:0] m);
    rd_a = m; cyc();
    rd_a = '0; cyc();
  endtask

  initial begin
    logic [5:0] exp_turbo;
    logic [3:0] exp_after_rst;
    exp_t e;

    vecs[0] = '{b0: 8'h09, b1: 8'h00, exp0: 10'h309, exp1: 10'h300};
    vecs[1] = '{b0: 8'hA5, b1: 8'h3C, exp0: 10'h3A5, exp1: 10'h33C};
    vecs[2] = '{b0: 8'hFF, b1: 8'h80, exp0: 10'h3FF, exp1: 10'h380};
    vecs[3] = '{b0: 8'h00, b1: 8'hFF, exp0: 10'h300, exp1: 10'h3FF};
    exp_turbo     = 6'b110011;
    exp_after_rst = 4'b1001;

    // Reset state
    #1 rst_n = 1'b0;
    cyc(); cyc();
    chk("rst_data_a", 16'(data_a), 16'h0);
    chk("rst_done_a", 16'(done_a), 16'h0);
    chk("rst_lp_a", 16'(lp_a), 16'h0);
    chk("rst_data_b", 16'(data_b), 16'h0);
    rst_n = 1'b1;
    cyc();

    // Turbo, period 2: bit0 turbo-gated, bit1 plain
    btns_a  = {8'h00, 8'h03};
    tmask_a = {8'h00, 8'h01};
    for (int i = 0; i < 6; i++) begin
      latch_a(2'b01);
      chk($sformatf("turbo_bit0_latch%0d", i + 1), 16'(data_a[0]), 16'(exp_turbo[i]));
      read_a(2'b01);
      chk($sformatf("turbo_bit1_latch%0d", i + 1), 16'(data_a[0]), 16'h1);
    end

    // Async reset mid-read (turbo phase is 0 here)
    btns_a = {8'h00, 8'h09};
    latch_a(2'b01);
    chk("pre_rst_suppressed", 16'(data_a[0]), 16'h0);
    for (int i = 0; i < 3; i++) read_a(2'b01);
    chk("pre_rst_bit3", 16'(data_a[0]), 16'h1);
    strobe_a = 2'b10; cyc();
    strobe_a = 2'b00; cyc();
    chk("pre_rst_lp", 16'(lp_a), 16'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", 16'(data_a), 16'h0);
    chk("async_rst_lp", 16'(lp_a), 16'h0);
    chk("async_rst_done", 16'(done_a), 16'h0);
    cyc();
    #2 rst_n = 1'b1;
    cyc();
    latch_a(2'b01);
    chk("post_rst_bit0", 16'(data_a[0]), 16'(exp_after_rst[0]));
    for (int k = 1; k < 4; k++) begin
      read_a(2'b01);
      chk($sformatf("post_rst_bit%0d", k), 16'(data_a[0]), 16'(exp_after_rst[k]));
    end
    tmask_a = '0;

    // Table-driven: both ports latched and read together, scoreboard queue
    foreach (vecs[v]) begin
      btns_a = {vecs[v].b1, vecs[v].b0};
      latch_a(2'b11);
      chk($sformatf("vec%0d_lp", v), 16'(lp_a), 16'h3);
      for (int k = 0; k < 10; k++) begin
        e.data = {vecs[v].exp1[k], vecs[v].exp0[k]};
        e.done = (k >= 8) ? 2'b11 : 2'b00;
        sb.push_back(e);
      end
      for (int k = 0; k < 10; k++) begin
        if (k > 0) read_a(2'b11);
        if (k == 1) chk($sformatf("vec%0d_lp_off", v), 16'(lp_a), 16'h0);
        e = sb.pop_front();
        chk($sformatf("vec%0d_data_r%0d", v, k), 16'(data_a), 16'(e.data));
        chk($sformatf("vec%0d_done_r%0d", v, k), 16'(done_a), 16'(e.done));
      end
    end

    // Load priority: rd pulses while strobe is held
    btns_a   = {8'h00, 8'h02};
    strobe_a = 2'b01; cyc();
    chk("prio_load_data", 16'(data_a[0]), 16'h0);
    chk("prio_load_done", 16'(done_a[0]), 16'h0);
    for (int i = 0; i < 3; i++) begin
      rd_a = 2'b01; cyc();
      rd_a = 2'b00; cyc();
      chk($sformatf("prio_rd%0d_data", i), 16'(data_a[0]), 16'h0);
      chk($sformatf("prio_rd%0d_done", i), 16'(done_a[0]), 16'h0);
    end
    strobe_a = 2'b00; cyc();
    chk("prio_lp_on", 16'(lp_a[0]), 16'h1);
    cyc();
    chk("prio_lp_off", 16'(lp_a[0]), 16'h0);
    chk("prio_bit0", 16'(data_a[0]), 16'h0);
    read_a(2'b01);
    chk("prio_bit1", 16'(data_a[0]), 16'h1);
    for (int i = 0; i < 6; i++) read_a(2'b01);
    chk("prio_done_after7", 16'(done_a[0]), 16'h0);
    read_a(2'b01);
    chk("prio_done_after8", 16'(done_a[0]), 16'h1);

    // Held rd gives one shift; back-to-back pulses give one each
    btns_a = {8'h00, 8'h05};
    latch_a(2'b01);
    chk("held_bit0", 16'(data_a[0]), 16'h1);
    rd_a = 2'b01;
    repeat (10) cyc();
    chk("held_no_shift", 16'(data_a[0]), 16'h1);
    rd_a = 2'b00; cyc();
    chk("held_one_shift", 16'(data_a[0]), 16'h0);
    read_a(2'b01);
    chk("b2b_bit2", 16'(data_a[0]), 16'h1);
    read_a(2'b01);
    chk("b2b_bit3", 16'(data_a[0]), 16'h0);

    // Extended pad, 16 bits
    btns_b   = 16'h8001;
    strobe_b = 1'b1; cyc();
    strobe_b = 1'b0; cyc();
    chk("ext_bit0", 16'(data_b), 16'h1);
    chk("ext_lp", 16'(lp_b), 16'h1);
    for (int k = 1; k <= 17; k++) begin
      rd_b = 1'b1; cyc();
      rd_b = 1'b0; cyc();
      chk($sformatf("ext_data_r%0d", k), 16'(data_b), (k >= 15) ? 16'h1 : 16'h0);
      chk($sformatf("ext_done_r%0d", k), 16'(done_b), (k >= 16) ? 16'h1 : 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
